// File: rtl/rom_arb_pkg.sv
// Shared defaults, response tag and cursor wrap helper for rom_read_arbiter.
package rom_arb_pkg;
  localparam int DEF_ROM_DEPTH = 973;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 64;
  localparam int MAX_REQ       = 8;

  // owner is one-hot; bits at or above NUM_REQ stay zero
  typedef struct packed {
    logic [MAX_REQ-1:0] owner;
    logic [31:0]        index;
    logic               wrap;
  } rsp_tag_t;

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [31:0] depth);
    return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction
endpackage

// File: rtl/rom_read_arbiter_if.sv
// Requester, ROM and response signals of rom_read_arbiter.
interface rom_read_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] restart;
  logic [NUM_REQ-1:0] gnt;
  logic               rom_en;
  logic [ADDR_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_data;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_W-1:0]  rsp_data;
  logic [31:0]        rsp_index;
  logic               rsp_wrap;

  modport master (output req, restart, rom_data,
                  input  gnt, rom_en, rom_addr, rsp_valid, rsp_data, rsp_index, rsp_wrap);
  modport slave  (input  req, restart, rom_data,
                  output gnt, rom_en, rom_addr, rsp_valid, rsp_data, rsp_index, rsp_wrap);
endinterface

// File: rtl/rom_read_arbiter_rr.sv
// One-hot grant arbiter: round-robin by default, strict lowest-index priority
// when ROM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
`ifdef ROM_ARB_FIXED_PRIO_EN
  // descending scan so the lowest requesting index is the last write
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) gnt = N'(1) << i;
  end
`else
  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr, ptr_nxt;
  logic [N-1:0]  cand;
  logic          found;
  int            j;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    cand    = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j    = (int'(ptr) + k) % N;
      cand = N'(1) << j;
      if (!found && (|(req & cand))) begin
        found   = 1'b1;
        gnt     = cand;
        ptr_nxt = PW'((j + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
`endif
endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one ROM read port between NUM_REQ cursor-based scanners.
// ROM_ARB_FIXED_PRIO_EN selects strict priority instead of round-robin.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ROM_DEPTH = DEF_ROM_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ROM_LAT   = 0
) (
  input logic               clk,
  input logic               rst,
  rom_read_arbiter_if.slave bus
);
  logic [NUM_REQ-1:0]             elig, gnt;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0][31:0]       idx;
  logic [ADDR_W-1:0]              sel_addr;
  logic [31:0]                    sel_idx;
  logic [MAX_REQ-1:0]             kill;
  logic                           enter_vld;
  logic [DATA_W-1:0]              data_q;
  rsp_tag_t                       pipe [0:ROM_LAT];

  // rst gates eligibility so gnt/rom_en drop as soon as reset asserts
  assign elig = bus.req & ~bus.restart & {NUM_REQ{~rst}};
  assign kill = MAX_REQ'(bus.restart);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (elig),
    .gnt (gnt)
  );

  always_comb begin
    sel_addr = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        sel_addr = addr[i];
        sel_idx  = idx[i];
      end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      idx  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.restart[i]) begin
          addr[i] <= '0;
          idx[i]  <= '0;
        end else if (gnt[i]) begin
          addr[i] <= ADDR_W'(next_addr(32'(addr[i]), 32'(ROM_DEPTH)));
          idx[i]  <= idx[i] + 32'd1;
        end
    end

  // a restarting requester's entries lose their valid bit as they advance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int s = 0; s <= ROM_LAT; s++) pipe[s] <= '0;
    end else begin
      pipe[0] <= '{owner: MAX_REQ'(gnt),
                   index: sel_idx,
                   wrap:  (32'(sel_addr) == 32'(ROM_DEPTH - 1))};
      for (int s = 1; s <= ROM_LAT; s++) begin
        pipe[s]       <= pipe[s-1];
        pipe[s].owner <= pipe[s-1].owner & ~kill;
      end
    end

  generate
    if (ROM_LAT == 0) begin : g_lat0
      assign enter_vld = |gnt;
    end else begin : g_latn
      assign enter_vld = |pipe[ROM_LAT-1].owner;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst)
    if (rst)            data_q <= '0;
    else if (enter_vld) data_q <= bus.rom_data;

  assign bus.gnt       = gnt;
  assign bus.rom_en    = |gnt;
  assign bus.rom_addr  = sel_addr;
  assign bus.rsp_valid = pipe[ROM_LAT].owner[NUM_REQ-1:0];
  assign bus.rsp_index = pipe[ROM_LAT].index;
  assign bus.rsp_wrap  = pipe[ROM_LAT].wrap;
  assign bus.rsp_data  = data_q;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter (ROM_LAT=2, ROM_DEPTH=4) with a
// queue-based reference model; honours ROM_ARB_FIXED_PRIO_EN.
module tb_rom_read_arbiter;
  localparam int N     = 2;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_chk  = 0;

  logic [63:0] rom [DEPTH];
  logic [15:0] ra1 = '0;
  logic [15:0] ra2 = '0;

  rom_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(16), .DATA_W(64)) bus ();

  rom_read_arbiter #(
    .NUM_REQ(N), .ROM_DEPTH(DEPTH), .ADDR_W(16), .DATA_W(64), .ROM_LAT(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // ROM with LAT cycles of read latency
  always @(posedge clk) begin
    ra1 <= bus.rom_addr;
    ra2 <= ra1;
  end
  assign bus.rom_data = rom[ra2[1:0]];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          owner;
    int unsigned index;
    bit          wrap;
    logic [63:0] data;
  } exp_t;

  exp_t        q[$];
  int          m_addr [N];
  int unsigned m_idx  [N];
  int          m_ptr, cyc, g, c, hit;
  logic [N-1:0] ev;

  initial begin
    cyc = 0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin m_addr[i] = 0; m_idx[i] = 0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        m_ptr = 0;
        for (int i = 0; i < N; i++) begin m_addr[i] = 0; m_idx[i] = 0; end
        check("m_rst_gnt", bus.gnt, 0);
        check("m_rst_rom_en", bus.rom_en, 0);
        check("m_rst_rsp_valid", bus.rsp_valid, 0);
      end else begin
        g = -1;
        for (int k = 0; k < N; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
          c = k;
`else
          c = (m_ptr + k) % N;
`endif
          if (g < 0 && bus.req[c] && !bus.restart[c]) g = c;
        end
        check("m_gnt", bus.gnt, (g >= 0) ? (64'd1 << g) : 64'd0);
        check("m_rom_en", bus.rom_en, (g >= 0) ? 64'd1 : 64'd0);
        check("m_rom_addr", bus.rom_addr, (g >= 0) ? 64'(m_addr[g]) : 64'd0);

        hit = -1;
        for (int e = 0; e < q.size(); e++) if (q[e].due == cyc) hit = e;
        ev = (hit >= 0) ? N'(1) << q[hit].owner : '0;
        check("m_rsp_valid", bus.rsp_valid, ev);
        if (hit >= 0) begin
          check("m_rsp_index", bus.rsp_index, q[hit].index);
          check("m_rsp_wrap", bus.rsp_wrap, q[hit].wrap);
          check("m_rsp_data", bus.rsp_data, q[hit].data);
          q.delete(hit);
        end

        for (int i = 0; i < N; i++)
          if (bus.restart[i]) begin
            for (int e = q.size() - 1; e >= 0; e--) if (q[e].owner == i) q.delete(e);
            m_addr[i] = 0;
            m_idx[i]  = 0;
          end
        if (g >= 0) begin
          q.push_back('{due: cyc + LAT + 1, owner: g, index: m_idx[g],
                        wrap: (m_addr[g] == DEPTH - 1), data: rom[m_addr[g]]});
          m_addr[g] = (m_addr[g] + 1) % DEPTH;
          m_idx[g]  = m_idx[g] + 1;
          m_ptr     = (g + 1) % N;
        end
      end
      cyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] rs);
    @(posedge clk);
    #1;
    bus.req     = r;
    bus.restart = rs;
  endtask

  logic [1:0]  ge, ve;
  logic [15:0] ae;
  int          ie;

  initial begin
    rom[0] = 64'd100;
    rom[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    rom[2] = 64'hFFFF_FFFF_FFFF_FFF9;
    rom[3] = 64'h7FFF_0000_1234_5678;
    rst = 1'b1;
    bus.req = '0;
    bus.restart = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", bus.gnt, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_index", bus.rsp_index, 0);
    check("rst_rsp_wrap", bus.rsp_wrap, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // both requesters active for 6 cycles, then drain
    for (int k = 0; k < 9; k++) begin
      drive((k < 6) ? 2'b11 : 2'b00, 2'b00);
      @(negedge clk);
`ifdef ROM_ARB_FIXED_PRIO_EN
      ge = (k < 6) ? 2'b01 : 2'b00;
      ae = (k < 6) ? 16'(k % 4) : 16'd0;
      ve = (k >= 3) ? 2'b01 : 2'b00;
      ie = k - 3;
`else
      ge = (k >= 6) ? 2'b00 : ((k % 2) != 0) ? 2'b10 : 2'b01;
      ae = (k < 6) ? 16'(k / 2) : 16'd0;
      ve = (k < 3) ? 2'b00 : (((k - 3) % 2) != 0) ? 2'b10 : 2'b01;
      ie = (k - 3) / 2;
`endif
      check("rr_gnt", bus.gnt, ge);
      check("rr_rom_addr", bus.rom_addr, ae);
      check("rr_rsp_valid", bus.rsp_valid, ve);
      if (ve != 2'b00) check("rr_rsp_index", bus.rsp_index, ie);
      if (ve != 2'b00 && ie == 2) check("rr_data_neg7", bus.rsp_data, 64'hFFFF_FFFF_FFFF_FFF9);
    end

    drive(2'b00, 2'b11);

    // requester 0 alone across two wraps of a 4-entry ROM
    for (int k = 0; k < 12; k++) begin
      drive((k < 9) ? 2'b01 : 2'b00, 2'b00);
      @(negedge clk);
      if (k < 9) begin
        check("wrap_gnt", bus.gnt, 2'b01);
        check("wrap_rom_addr", bus.rom_addr, k % 4);
      end
      if (k >= 3) begin
        check("wrap_rsp_valid", bus.rsp_valid, 2'b01);
        check("wrap_rsp_index", bus.rsp_index, k - 3);
        check("wrap_rsp_wrap", bus.rsp_wrap, ((k - 3) % 4) == 3);
      end
    end

    // restart beats req for requester 1 and kills its two in-flight reads
    for (int k = 0; k < 8; k++) begin
      drive((k < 4) ? 2'b10 : 2'b00, (k == 2) ? 2'b10 : 2'b00);
      @(negedge clk);
      check("rs_gnt", bus.gnt, (k == 0 || k == 1 || k == 3) ? 2'b10 : 2'b00);
      check("rs_rsp_valid", bus.rsp_valid, (k == 6) ? 2'b10 : 2'b00);
      if (k == 3) check("rs_rom_addr", bus.rom_addr, 0);
      if (k == 6) check("rs_rsp_index", bus.rsp_index, 0);
    end

    // asynchronous reset with reads in flight
    drive(2'b11, 2'b00);
    drive(2'b11, 2'b00);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_gnt", bus.gnt, 0);
    check("arst_rom_en", bus.rom_en, 0);
    check("arst_rom_addr", bus.rom_addr, 0);
    check("arst_rsp_valid", bus.rsp_valid, 0);
    check("arst_rsp_data", bus.rsp_data, 0);
    check("arst_rsp_index", bus.rsp_index, 0);
    check("arst_rsp_wrap", bus.rsp_wrap, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req = 2'b11;
    @(negedge clk);
    check("post_rst_gnt", bus.gnt, 2'b01);
    check("post_rst_rom_addr", bus.rom_addr, 0);
    repeat (5) drive(2'b00, 2'b00);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares the single read port of the puzzle-input ROM between NUM_REQ sequential scanners, such as the outer and inner running-sum walkers of the repeated-frequency search.
- Keeps one wrapping cursor per requester (physical address 0..ROM_DEPTH-1 plus a 32-bit logical index) and advances that cursor on each grant.
- Returns each read tagged with its requester, index and wrap flag.
- Requesters no longer manage ROM addresses or wrap-around themselves.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ROM_DEPTH, 973: number of ROM entries; the cursor wraps after ROM_DEPTH-1.
- ADDR_W, 16: ROM address width.
- DATA_W, 64: signed ROM data width.
- ROM_LAT, 0: ROM read latency in cycles (0..4); 0 means a combinational ROM.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: reset, asynchronous, active-high.
- req, input, NUM_REQ: requester i wants its next entry; level, sampled every cycle.
- restart, input, NUM_REQ: rewind cursor i to address 0, index 0.
- gnt, output, NUM_REQ: one-hot or zero; the read issued this cycle belongs to this requester.
- rom_en, output, 1: ROM read enable; equals OR of gnt.
- rom_addr, output, ADDR_W: cursor of the granted requester; 0 when idle.
- rom_data, input, DATA_W: ROM output, valid ROM_LAT cycles after rom_en.
- rsp_valid, output, NUM_REQ: one-hot; rsp_* below belong to this requester.
- rsp_data, output, DATA_W: signed ROM word.
- rsp_index, output, 32: logical index of the word (reads of this requester since its last restart, 0-based).
- rsp_wrap, output, 1: word came from address ROM_DEPTH-1.

Behaviour:
- Reset, asynchronous on rst=1:
  - gnt=0, rom_en=0, rom_addr=0, rsp_valid=0, rsp_data=0, rsp_index=0, rsp_wrap=0.
  - All cursors and indices 0; round-robin pointer 0, so requester 0 has highest priority first.
  - All in-flight reads are discarded.
- Eligibility: requester i is eligible when req[i]=1 and restart[i]=0. Restart always wins over req in the same cycle.
- Arbitration (combinational, same cycle):
  - At most one grant per cycle.
  - Round-robin: the search starts at the pointer and wraps modulo NUM_REQ.
  - After a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no grant the pointer is held.
- On grant to i:
  - rom_addr = addr[i].
  - Next cycle: addr[i] becomes 0 if addr[i]==ROM_DEPTH-1, else addr[i]+1. idx[i] becomes idx[i]+1, wrapping modulo 2^32.
  - The same requester may be granted on consecutive cycles if it is the only eligible one.
- Response pipeline: ROM_LAT+1 register stages carry {gnt one-hot, idx, wrap flag}.
  - rsp_data is captured from rom_data at stage ROM_LAT.
  - rsp_* become valid exactly ROM_LAT+1 cycles after the grant cycle and are held for one cycle only.
  - Throughput is one response per cycle.
  - Responses for one requester arrive in grant order.
- Restart[i] in cycle t:
  - addr[i]=0 and idx[i]=0 from cycle t+1.
  - Every in-flight entry tagged i has its valid bit cleared, so it never appears on rsp_valid. Other requesters' entries are unaffected.
- There is no backpressure on rsp. Requesters must accept every rsp_valid pulse.
- Arithmetic: rsp_data is passed through unmodified; sign handling is the requester's job.

Optional Feature:
- Macro: ROM_ARB_FIXED_PRIO_EN.
- Defined: strict fixed priority, lowest index wins. The pointer logic is removed, which allows the inner walker to starve the outer one by design.
- Undefined (default): round-robin as specified above.
- Ports and latency are identical in both builds.

Decomposition:
- Shared package rom_arb_pkg holds:
  - the localparam defaults for ROM_DEPTH, ADDR_W and DATA_W;
  - typedef rsp_tag_t {NUM_REQ-bit owner, 32-bit index, wrap};
  - function next_addr(addr) implementing the wrap rule.
- One sub-module: rr_arbiter (req vector in, one-hot grant out, pointer register inside, fixed-priority path under the macro).

Test Plan:
- Reset mid-stream: with ROM_LAT=2 and reads in flight, assert rst asynchronously between edges -> all outputs 0 immediately; after release, the first grant goes to requester 0 with rom_addr=0.
- Round-robin: req=2'b11 held 6 cycles -> gnt sequence 01,10,01,10,01,10; each requester sees rsp_index 0,1,2; rsp_valid arrives ROM_LAT+1 cycles after each gnt.
- Wrap: ROM_DEPTH=4, req[0] alone for 9 cycles -> rom_addr 0,1,2,3,0,1,2,3,0; rsp_wrap=1 on indices 3 and 7; rsp_index reaches 8.
- Restart priority: restart[1]=1 and req[1]=1 in the same cycle with two reads of requester 1 in flight -> no gnt[1] that cycle; neither in-flight response appears; the next grant to 1 has addr 0 and index 0.
- Data passthrough: ROM word at addr 2 = -7 (0xFFFF_FFFF_FFFF_FFF9) -> rsp_data is identical for both requesters' reads of index 2.
- Fixed priority build (ROM_ARB_FIXED_PRIO_EN defined): req=2'b11 for 5 cycles -> gnt=01 every cycle; requester 1 gets no grant.
